spi_slave_responder: RTL
========================

// Module: spi_slave_responder
// PURPOSE
//   SPI mode-0 (CPOL=0, CPHA=0) slave: the far end of the CPU's SPI master link.
//   Oversamples sclk/cs_n/mosi on the system clock, deserialises MOSI bytes to the
//   host side and serialises host-supplied bytes onto MISO, MSB first.
//   Used as bench responder for the SPI register file and as on-chip peripheral endpoint.
// PARAMETERS
//   DATA_W   8  bits per SPI word (shift length, rx_data/tx_data width)
//   SYNC_STG 2  synchroniser flops on sclk, cs_n, mosi (>=2)
// PORTS
//   clk       in   1       system clock; all state on posedge
//   rst       in   1       synchronous, active-high reset
//   sclk      in   1       SPI clock from master (async to clk)
//   cs_n      in   1       chip select, active low (async)
//   mosi      in   1       master-out data (async)
//   miso      out  1       slave-out data
//   miso_oe   out  1       MISO drive enable; 0 = release line
//   tx_data   in   DATA_W  next word to send
//   tx_valid  in   1       tx_data valid
//   tx_ready  out  1       holding buffer empty; load when tx_valid&&tx_ready
//   rx_data   out  DATA_W  last received word, held until next word completes
//   rx_valid  out  1       one-clk pulse: rx_data updated
// BEHAVIOUR
//   Reset: miso=0, miso_oe=0, rx_data=0, rx_valid=0, tx_ready=1, bit_cnt=0, state IDLE.
//   Inputs pass SYNC_STG flops; edges detected on synced copies (one more flop).
//   Timing req: sclk high and low each >= SYNC_STG+2 clk periods.
//   FSM IDLE: miso_oe=0. Synced cs_n fall -> SHIFT; same cycle load tx_shift from
//     holding buffer (buffer freed, tx_ready=1 next clk); miso=tx_shift MSB; miso_oe=1.
//   FSM SHIFT: sclk rise -> rx_shift={rx_shift[DATA_W-2:0],mosi}, bit_cnt++.
//     sclk fall -> tx_shift<<=1, miso=new MSB; except when bit_cnt==DATA_W:
//     bit_cnt=0, reload tx_shift from holding buffer, miso=its MSB (back-to-back words).
//   Word complete: on rise making bit_cnt==DATA_W, next clk rx_data=full word,
//     rx_valid=1 for exactly one clk. Latency pad edge -> rx_valid <= SYNC_STG+2 clk.
//   Empty buffer at load point: send all-zeros word (see CONFIGURATION).
//   tx_valid&&tx_ready in same clk as a load: load sees old (empty) buffer; new word
//     held for next load point. tx_ready=0 while buffer full.
//   cs_n rise in SHIFT (any bit_cnt): -> IDLE, miso_oe=0, bit_cnt=0, partial rx
//     discarded (no rx_valid); word already loaded into tx_shift is dropped.
//   cs_n rise coincident with completing rise: rx_valid still issued.
//   rst mid-transfer: all state to reset values; holding buffer emptied.
//   sclk edges while cs_n high: ignored.
// CONFIGURATION
//   SPI_SLAVE_ECHO_EN defined: empty buffer at load point -> send last rx_data
//     (echo; 0 after reset). Undefined: send all-zeros. No other difference.
// STRUCTURE
//   Package spi_pkg: state enum {IDLE,SHIFT}, SPI mode constants, default DATA_W,
//     min-oversample constant shared with master bench.
//   Sub-module spi_sync_edge: SYNC_STG-deep synchroniser + rise/fall pulse outputs;
//     instanced for sclk and cs_n (mosi uses sync only).
// TESTING
//   Single word: tx 0xA5 loaded, master sends 0x3C -> rx_data=0x3C, one rx_valid
//     pulse; master captures 0xA5; miso_oe high only while cs_n low.
//   Back-to-back: two words 0x11,0x22 queued in time, master clocks 16 bits one cs ->
//     rx 0x81 then 0x7E with two rx_valid pulses; master reads 0x11,0x22.
//   Underrun: no tx loaded, master reads 0x00; with SPI_SLAVE_ECHO_EN after rx 0x5A
//     next empty read returns 0x5A.
//   Abort: cs_n rises after 5 bits -> no rx_valid, bit_cnt=0; next full word 0xC3
//     received correctly.
//   Reset mid-word: rst after 3 bits -> miso_oe=0, tx_ready=1, rx_valid never seen;
//     following transfer correct.
//   Handshake: tx_valid held with tx_ready=0 -> no overwrite; accepted 1 clk after load.

Source files
------------

// File: rtl/spi_slave_responder_pkg.sv
// Shared definitions for the SPI mode-0 slave responder and its master bench.
//   state_t            : responder FSM states (IDLE, SHIFT)
//   SPI_MODE/CPOL/CPHA : SPI mode constants (mode 0)
//   SPI_DATA_W         : default word width
//   SPI_SYNC_STG       : default synchroniser depth
//   SPI_MIN_OVERSAMPLE : minimum sclk high/low time in system clocks
package spi_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [1:0] SPI_MODE = 2'b00;
  localparam logic SPI_CPOL = SPI_MODE[1];
  localparam logic SPI_CPHA = SPI_MODE[0];

  localparam int SPI_DATA_W   = 8;
  localparam int SPI_SYNC_STG = 2;

  // Synchroniser depth + edge flop + one clock to act on the edge.
  function automatic int min_half_clks(input int sync_stg);
    return sync_stg + 2;
  endfunction

  localparam int SPI_MIN_OVERSAMPLE = min_half_clks(SPI_SYNC_STG);
endpackage

// File: rtl/spi_slave_responder_if.sv
// Bus interface for spi_slave_responder: SPI pins plus host tx/rx handshake.
//   SPI side : sclk, cs_n, mosi (to slave), miso, miso_oe (from slave)
//   Host side: tx_data/tx_valid (to slave), tx_ready, rx_data, rx_valid (from slave)
// Modports: slave (the responder), master (SPI master + host driver).
interface spi_slave_responder_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_responder_sync_edge.sv
// spi_sync_edge: SYNC_STG-deep synchroniser for an asynchronous input followed
// by one history flop, producing single-clock rise/fall pulses.
//   clk_i, rst_i : system clock, synchronous active-high reset
//   d_i          : asynchronous input
//   rise_o/fall_o: one-clock pulses on synced 0->1 / 1->0 transitions
// RST_VAL is the line's idle level so releasing reset does not fake an edge.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   SYNC_STG = SPI_SYNC_STG,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STG-1:0] sync_q;
  logic                prev_q;
  logic                lvl;

  assign lvl = sync_q[SYNC_STG-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STG{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], d_i};
      prev_q <= lvl;
    end
  end

  assign rise_o = lvl & ~prev_q;
  assign fall_o = ~lvl & prev_q;
endmodule

// File: rtl/spi_slave_responder.sv
// spi_slave_responder: SPI mode-0 slave, oversampled on the system clock.
// Deserialises MOSI into rx_data (rx_valid pulse per word) and serialises
// host-supplied words from a one-deep holding buffer onto MISO, MSB first.
//   clk_i : system clock          rst_i : synchronous active-high reset
//   bus   : spi_slave_responder_if.slave (SPI pins + tx/rx handshake)
// Build option: SPI_SLAVE_ECHO_EN -- when the holding buffer is empty at a
// load point, send the last rx_data instead of an all-zeros word.
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int DATA_W   = SPI_DATA_W,
  parameter int SYNC_STG = SPI_SYNC_STG
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  spi_slave_responder_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STG-1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(SPI_CPOL)) u_sclk_sync (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(bus.sclk),
    .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_cs_sync (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(bus.cs_n),
    .rise_o(cs_rise), .fall_o(cs_fall)
  );

  // mosi gets the same depth as sclk so it lines up with the detected rise.
  always_ff @(posedge clk_i) begin
    if (rst_i) mosi_sync_q <= '0;
    else       mosi_sync_q <= {mosi_sync_q[SYNC_STG-2:0], bus.mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STG-1];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0] rx_shift_q, rx_shift_d;   // the last bit comes straight from mosi_s
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] empty_word, load_word;

`ifdef SPI_SLAVE_ECHO_EN
  assign empty_word = rx_data_q;
`else
  assign empty_word = '0;
`endif
  assign load_word = hold_full_q ? hold_q : empty_word;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    case (state_q)
      IDLE: begin
        miso_oe_d = 1'b0;
        if (cs_fall) begin
          state_d     = SHIFT;
          bit_cnt_d   = '0;
          tx_shift_d  = load_word;
          miso_d      = load_word[DATA_W-1];
          miso_oe_d   = 1'b1;
          hold_full_d = 1'b0;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-3:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            rx_data_d  = {rx_shift_q, mosi_s};
            rx_valid_d = 1'b1;
          end
        end else if (sclk_fall && !cs_rise) begin
          if (bit_cnt_q == CNT_W'(DATA_W)) begin
            // Word boundary: start the next word without a cs_n cycle.
            bit_cnt_d   = '0;
            tx_shift_d  = load_word;
            miso_d      = load_word[DATA_W-1];
            hold_full_d = 1'b0;
          end else begin
            tx_shift_d = tx_shift_q << 1;
            miso_d     = tx_shift_q[DATA_W-2];
          end
        end
        // Deselect aborts the word; a word completed on this same clock still reports.
        if (cs_rise) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept after the load decision so a same-clock load sees the old, empty buffer.
    if (bus.tx_valid && !hold_full_q) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign bus.miso     = miso_q;
  assign bus.miso_oe  = miso_oe_q;
  assign bus.tx_ready = ~hold_full_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
endmodule
